dsc_mul_ctrl: RTL
=================

Name: dsc_mul_ctrl

Overview:
- Single-clock sequencer that sits between an operand source and the 4-input deterministic stochastic multiplier (dsc_mul, 10-bit SNGs, 40-bit count).
- Accepts one operand set per valid/ready handshake, clears the multiplier and holds the operands stable while it runs, and waits for the multiplier's chain-overflow flag.
- Captures the 40-bit count and rounds it back to a SNG_WIDTH-bit fraction. Presents the raw and rounded results on a valid/ready output with a watchdog error flag.

Parameters:
- SNG_WIDTH, 10, bits per operand and rounded result
- NUM_INPUTS, 4, operand count; raw width RW = NUM_INPUTS*SNG_WIDTH
- CLR_CYCLES, 2, cycles mul_rst is held high before a run
- DRAIN_CYCLES, 2, cycles waited after the ov edge before sampling mul_z
- WD_WIDTH, 42, watchdog counter width; 0 disables the watchdog

Ports:
- clk in 1: system clock
- rst in 1: synchronous, active-high reset
- in_valid in 1: operand set valid
- in_ready out 1: controller can accept operands
- in_a, in_b, in_c, in_d in SNG_WIDTH: operands, unsigned fractions x/2^SNG_WIDTH
- mul_a, mul_b, mul_c, mul_d out SNG_WIDTH: registered operands to dsc_mul
- mul_rst out 1: clear to dsc_mul
- mul_en out 1: run enable to dsc_mul
- mul_z in RW: dsc_mul count
- mul_ov in 1: dsc_mul final overflow
- out_valid out 1: result valid
- out_ready in 1: consumer accepts result
- out_z_raw out RW: captured count
- out_z out SNG_WIDTH: rounded product
- out_err out 1: watchdog expired; result invalid
- busy out 1: state != IDLE

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE; in_ready=1; mul_en=0; mul_rst=1 (multiplier held cleared while idle).
  - out_valid=0, out_z_raw=0, out_z=0, out_err=0.
  - mul_a..d=0; ov_q=0; counters=0.
  - rst mid-run aborts the run and drops any pending result; no out_valid is produced.
- FSM states: IDLE, CLEAR, RUN, DRAIN, HOLD.
  - IDLE: in_ready=1, mul_rst=1. On in_valid&in_ready, register in_a..d into mul_a..d, load clr_cnt=CLR_CYCLES-1, go to CLEAR.
  - CLEAR: mul_rst=1, mul_en=0; clr_cnt decrements; at 0 go to RUN. mul_rst is asserted for exactly CLR_CYCLES cycles after the accept cycle.
  - RUN: mul_rst=0, mul_en=1, watchdog increments each cycle.
    - Rising edge of mul_ov (mul_ov & ~ov_q; ov_q is a one-cycle register) goes to DRAIN with dr_cnt=DRAIN_CYCLES-1.
    - A level already high on entry to RUN is not an edge.
    - Watchdog all-ones before the edge: set out_err=1 and go to HOLD with out_z_raw=mul_z as-is.
  - DRAIN: mul_en=0; dr_cnt decrements. At 0, capture out_z_raw<=mul_z, compute out_z, set out_valid=1, go to HOLD.
  - HOLD: out_valid=1, outputs stable until out_valid&out_ready. Then clear out_valid and out_err and return to IDLE. The next in_valid is accepted on the following cycle; there is no same-cycle turnaround.
- mul_a..d change only in IDLE on accept and are stable through CLEAR/RUN/DRAIN/HOLD.
- in_ready=1 only in IDLE.
- Rounding:
  - S = (NUM_INPUTS-1)*SNG_WIDTH.
  - t = (out_z_raw + 2^(S-1)) >> S, computed in RW+1 bits.
  - out_z = (t > 2^SNG_WIDTH-1) ? 2^SNG_WIDTH-1 : t (round half up, saturating).
- Latency, accept to out_valid: 1 + CLR_CYCLES + run_cycles + DRAIN_CYCLES.
- mul_ov edge while in CLEAR/DRAIN/HOLD/IDLE: ignored; ov_q still tracks.
- out_ready while out_valid=0: ignored.

Decomposition:
- Package dsc_pkg: SNG_WIDTH/NUM_INPUTS defaults, RW and S derivations, FSM state encoding (3-bit localparams), rounding shift constant.
- One sub-module, dsc_round_sat (combinational round-half-up + saturate, params RW, SNG_WIDTH), so dsc_mul_ctrl stays a pure sequencer.
- The bench uses a stub for dsc_mul that raises mul_ov after N programmable cycles of mul_en and drives a programmed mul_z.

Test Plan:
- Reset, then in_valid with a=b=c=d=512; stub ov after 20 cycles, mul_z=2^36 -> mul_rst high 2 cycles, mul_en high 20 cycles, out_z_raw=0x10_0000_0000, out_z=64, out_err=0.
- Operands all 1023; stub mul_z=1023^4=1095222947841 -> out_z=1020; any operand 0 with mul_z=0 -> out_z=0.
- Stub mul_z=2^40-1 -> out_z=1023 (saturation). Stub mul_z=2^29 -> out_z=1 (half rounds up); mul_z=2^29-1 -> out_z=0.
- out_ready held low 10 cycles in HOLD -> out_valid and data stable; in_valid pulses during the run are not accepted (in_ready=0, mul_a unchanged).
- WD_WIDTH=4, stub never raises ov -> out_err=1 with out_valid after 16 RUN cycles; after the handshake, the next operand set runs normally.
- rst asserted for one cycle mid-RUN -> next cycle state IDLE, mul_en=0, mul_rst=1, out_valid never asserted for the aborted set.

Source files
------------

// File: rtl/dsc_pkg.sv
// Shared constants and FSM encoding for the deterministic stochastic multiplier controller.
// Rounding shift S drops all but the top SNG_WIDTH fraction bits of the raw count.
package dsc_pkg;

    localparam int unsigned SNG_WIDTH_DEF  = 10;
    localparam int unsigned NUM_INPUTS_DEF = 4;
    localparam int unsigned RW_DEF         = NUM_INPUTS_DEF * SNG_WIDTH_DEF;
    localparam int unsigned S_DEF          = (NUM_INPUTS_DEF - 1) * SNG_WIDTH_DEF;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StRun   = 3'd2,
        StDrain = 3'd3,
        StHold  = 3'd4
    } state_e;

    function automatic int unsigned round_shift(input int unsigned num_inputs,
                                                input int unsigned sng_width);
        return (num_inputs - 1) * sng_width;
    endfunction

endpackage

// File: rtl/dsc_round_sat.sv
// Round-half-up of the raw multiplier count to a SNG_WIDTH-bit fraction, saturating at all-ones.
// The sum is formed one bit wider than the count so the rounding increment cannot wrap.
module dsc_round_sat
    import dsc_pkg::*;
#(
    parameter int unsigned RW        = RW_DEF,
    parameter int unsigned SNG_WIDTH = SNG_WIDTH_DEF
) (
    input  logic [RW-1:0]        z_raw,
    output logic [SNG_WIDTH-1:0] z
);

    localparam int unsigned S = RW - SNG_WIDTH;
    localparam logic [RW:0] Half = (RW + 1)'(1) << (S - 1);
    localparam logic [RW:0] ZMax = {{(RW + 1 - SNG_WIDTH){1'b0}}, {SNG_WIDTH{1'b1}}};

    logic [RW:0] sum;
    logic [RW:0] t;

    always_comb begin
        sum = {1'b0, z_raw} + Half;
        t   = sum >> S;
        if (t > ZMax) begin
            z = {SNG_WIDTH{1'b1}};
        end else begin
            z = t[SNG_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/dsc_mul_ctrl.sv
// Sequencer for dsc_mul: accepts operands, clears and runs the multiplier until its overflow
// edge, then presents the raw count and its rounded fraction on a valid/ready output.
module dsc_mul_ctrl
    import dsc_pkg::*;
#(
    parameter int unsigned SNG_WIDTH    = SNG_WIDTH_DEF,
    parameter int unsigned NUM_INPUTS   = NUM_INPUTS_DEF,
    parameter int unsigned CLR_CYCLES   = 2,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned WD_WIDTH     = 42,
    localparam int unsigned RW          = NUM_INPUTS * SNG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SNG_WIDTH-1:0] in_a,
    input  logic [SNG_WIDTH-1:0] in_b,
    input  logic [SNG_WIDTH-1:0] in_c,
    input  logic [SNG_WIDTH-1:0] in_d,
    output logic [SNG_WIDTH-1:0] mul_a,
    output logic [SNG_WIDTH-1:0] mul_b,
    output logic [SNG_WIDTH-1:0] mul_c,
    output logic [SNG_WIDTH-1:0] mul_d,
    output logic                 mul_rst,
    output logic                 mul_en,
    input  logic [RW-1:0]        mul_z,
    input  logic                 mul_ov,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RW-1:0]        out_z_raw,
    output logic [SNG_WIDTH-1:0] out_z,
    output logic                 out_err,
    output logic                 busy
);

    localparam int unsigned CntMax = (CLR_CYCLES > DRAIN_CYCLES) ? CLR_CYCLES : DRAIN_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    // A zero-width watchdog still needs one bit of storage; it is never allowed to expire.
    localparam int unsigned WdW    = (WD_WIDTH > 0) ? WD_WIDTH : 1;

    state_e              state;
    logic                ov_q;
    logic [CntW-1:0]     clr_cnt;
    logic [CntW-1:0]     dr_cnt;
    logic [WdW-1:0]      wd_cnt;
    logic                wd_expired;
    logic [SNG_WIDTH-1:0] z_round;

    dsc_round_sat #(
        .RW        (RW),
        .SNG_WIDTH (SNG_WIDTH)
    ) u_round (
        .z_raw (mul_z),
        .z     (z_round)
    );

    assign in_ready   = (state == StIdle);
    assign busy       = (state != StIdle);
    assign wd_expired = (WD_WIDTH != 0) && (&wd_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            mul_rst   <= 1'b1;
            mul_en    <= 1'b0;
            out_valid <= 1'b0;
            out_z_raw <= '0;
            out_z     <= '0;
            out_err   <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_c     <= '0;
            mul_d     <= '0;
            ov_q      <= 1'b0;
            clr_cnt   <= '0;
            dr_cnt    <= '0;
            wd_cnt    <= '0;
        end else begin
            ov_q <= mul_ov;
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        mul_a   <= in_a;
                        mul_b   <= in_b;
                        mul_c   <= in_c;
                        mul_d   <= in_d;
                        clr_cnt <= CntW'(CLR_CYCLES - 1);
                        state   <= StClear;
                    end
                end
                StClear: begin
                    if (clr_cnt == '0) begin
                        mul_rst <= 1'b0;
                        mul_en  <= 1'b1;
                        wd_cnt  <= '0;
                        state   <= StRun;
                    end else begin
                        clr_cnt <= clr_cnt - CntW'(1);
                    end
                end
                StRun: begin
                    wd_cnt <= wd_cnt + WdW'(1);
                    // Only a fresh edge counts; a level already high on entry is stale.
                    if (mul_ov && !ov_q) begin
                        mul_en <= 1'b0;
                        dr_cnt <= CntW'(DRAIN_CYCLES - 1);
                        state  <= StDrain;
                    end else if (wd_expired) begin
                        mul_en    <= 1'b0;
                        out_z_raw <= mul_z;
                        out_z     <= z_round;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= StHold;
                    end
                end
                StDrain: begin
                    if (dr_cnt == '0) begin
                        out_z_raw <= mul_z;
                        out_z     <= z_round;
                        out_valid <= 1'b1;
                        state     <= StHold;
                    end else begin
                        dr_cnt <= dr_cnt - CntW'(1);
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        mul_rst   <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    mul_rst <= 1'b1;
                    mul_en  <= 1'b0;
                    state   <= StIdle;
                end
            endcase
        end
    end

endmodule
